// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register and write-back stage of the 5-stage RV32I pipeline.
// Holds the MEM-stage result bundle, extracts load data and drives the
// register-file write port (rd / DataWr / RUWr). The register file writes on
// negedge, so every output here is derived only from the stage register and
// stays stable from posedge to posedge. Also keeps the retired-instruction
// counter.
module mem_wb_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [4:0]       in_rd,
  input  logic             in_rf_wr,
  input  logic [1:0]       in_wb_sel,
  input  logic [2:0]       in_funct3,
  input  logic [1:0]       in_addr_lo,
  input  logic [XLEN-1:0]  in_alu_res,
  input  logic [XLEN-1:0]  in_load_word,
  input  logic [XLEN-1:0]  in_pc_plus4,
  output logic [4:0]       wb_rd,
  output logic [XLEN-1:0]  wb_data,
  output logic             wb_en,
  output logic             wb_valid,
  output logic [CNT_W-1:0] instret
);

  typedef enum logic [1:0] {
    WB_ALU  = 2'b00,
    WB_LOAD = 2'b01,
    WB_PC4  = 2'b10,
    WB_RSVD = 2'b11
  } wb_sel_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef struct packed {
    logic            valid;
    logic [4:0]      rd;
    logic            rf_wr;
    wb_sel_e         wb_sel;
    logic [2:0]      funct3;
    logic [1:0]      addr_lo;
    logic [XLEN-1:0] alu_res;
    logic [XLEN-1:0] load_word;
    logic [XLEN-1:0] pc_plus4;
  } stage_t;

  stage_t           stage_q;
  stage_t           stage_d;
  logic [CNT_W-1:0] instret_q;
  logic [7:0]       ld_byte;
  logic [15:0]      ld_half;
  logic [XLEN-1:0]  ld_data;

  // Pack the incoming MEM-stage bundle; a bubble is simply in_valid=0.
  always_comb begin
    stage_d = '{
      valid:     in_valid,
      rd:        in_rd,
      rf_wr:     in_rf_wr,
      wb_sel:    wb_sel_e'(in_wb_sel),
      funct3:    in_funct3,
      addr_lo:   in_addr_lo,
      alu_res:   in_alu_res,
      load_word: in_load_word,
      pc_plus4:  in_pc_plus4
    };
  end

  // Stage register: flush beats stall, stall beats capture.
  // NOTE: state uses non-blocking assignments with an async reset so every
  // flop samples pre-edge values and clears the moment rst_n falls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_q <= '0;
    end else if (flush) begin
      stage_q <= '0;
    end else if (!stall) begin
      stage_q <= stage_d;
    end
  end

  // Count an instruction when the valid held entry leaves the stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instret_q <= '0;
    end else if (stage_q.valid && (!stall || flush)) begin
      instret_q <= instret_q + CNT_W'(1);
    end
  end

  // Load alignment and sign/zero extension; halfword ignores addr_lo[0].
  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    ld_data = stage_q.load_word;
    ld_byte = stage_q.load_word[{stage_q.addr_lo, 3'b000} +: 8];
    ld_half = stage_q.addr_lo[1] ? stage_q.load_word[31:16]
                                 : stage_q.load_word[15:0];
    case (stage_q.funct3)
      F3_LB:   ld_data = {{(XLEN-8){ld_byte[7]}}, ld_byte};
      F3_LBU:  ld_data = {{(XLEN-8){1'b0}}, ld_byte};
      F3_LH:   ld_data = {{(XLEN-16){ld_half[15]}}, ld_half};
      F3_LHU:  ld_data = {{(XLEN-16){1'b0}}, ld_half};
      default: ld_data = stage_q.load_word;
    endcase
  end

  // Write-back value select; the reserved encoding writes zero.
  always_comb begin
    wb_data = '0;
    case (stage_q.wb_sel)
      WB_ALU:  wb_data = stage_q.alu_res;
      WB_LOAD: wb_data = ld_data;
      WB_PC4:  wb_data = stage_q.pc_plus4;
      default: wb_data = '0;
    endcase
  end

  // x0 and the reserved select never write; a stalled entry rewrites the
  // same value each cycle, which the register file tolerates.
  assign wb_en    = stage_q.valid & stage_q.rf_wr & (stage_q.rd != 5'd0)
                  & (stage_q.wb_sel != WB_RSVD);
  assign wb_rd    = stage_q.rd;
  assign wb_valid = stage_q.valid;
  assign instret  = instret_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Scoreboard bench for mem_wb_stage. Stimulus pushes the hand-computed
// expectation of whatever entry the stage will hold after each edge; a
// negedge monitor pops and compares whenever the stage shows a valid entry.
// A second instance with a 4-bit counter exercises instret wrap-around.
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, flush;
  logic        in_valid, in_rf_wr;
  logic [4:0]  in_rd;
  logic [1:0]  in_wb_sel, in_addr_lo;
  logic [2:0]  in_funct3;
  logic [31:0] in_alu_res, in_load_word, in_pc_plus4;

  logic [4:0]  wb_rd, nw_wb_rd;
  logic [31:0] wb_data, nw_wb_data;
  logic        wb_en, wb_valid, nw_wb_en, nw_wb_valid;
  logic [63:0] instret;
  logic [3:0]  nw_instret;

  always #5 clk = ~clk;

  mem_wb_stage #(.XLEN(32), .CNT_W(64)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
    .in_valid(in_valid), .in_rd(in_rd), .in_rf_wr(in_rf_wr),
    .in_wb_sel(in_wb_sel), .in_funct3(in_funct3), .in_addr_lo(in_addr_lo),
    .in_alu_res(in_alu_res), .in_load_word(in_load_word),
    .in_pc_plus4(in_pc_plus4),
    .wb_rd(wb_rd), .wb_data(wb_data), .wb_en(wb_en), .wb_valid(wb_valid),
    .instret(instret)
  );

  mem_wb_stage #(.XLEN(32), .CNT_W(4)) dut_w (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
    .in_valid(in_valid), .in_rd(in_rd), .in_rf_wr(in_rf_wr),
    .in_wb_sel(in_wb_sel), .in_funct3(in_funct3), .in_addr_lo(in_addr_lo),
    .in_alu_res(in_alu_res), .in_load_word(in_load_word),
    .in_pc_plus4(in_pc_plus4),
    .wb_rd(nw_wb_rd), .wb_data(nw_wb_data), .wb_en(nw_wb_en),
    .wb_valid(nw_wb_valid), .instret(nw_instret)
  );

  typedef struct {
    logic        valid;
    logic [4:0]  rd;
    logic        rf_wr;
    logic [1:0]  sel;
    logic [2:0]  f3;
    logic [1:0]  lo;
    logic [31:0] alu;
    logic [31:0] word;
    logic [31:0] pc;
    logic [31:0] exp_data;
    logic        exp_en;
    int          id;
  } vec_t;

  vec_t        sb[$];
  vec_t        held;
  vec_t        mon_e;
  logic        held_valid = 1'b0;
  logic [63:0] exp_cnt = '0;
  int          next_id = 0;
  int          errors = 0;
  int          checks = 0;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic valid, input logic [4:0] rd,
                              input logic rf_wr, input logic [1:0] sel,
                              input logic [2:0] f3, input logic [1:0] lo,
                              input logic [31:0] alu, input logic [31:0] word,
                              input logic [31:0] pc, input logic [31:0] exp_data,
                              input logic exp_en);
    vec_t v;
    v.valid = valid; v.rd = rd; v.rf_wr = rf_wr; v.sel = sel; v.f3 = f3;
    v.lo = lo; v.alu = alu; v.word = word; v.pc = pc;
    v.exp_data = exp_data; v.exp_en = exp_en; v.id = 0;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    in_valid = v.valid; in_rd = v.rd; in_rf_wr = v.rf_wr; in_wb_sel = v.sel;
    in_funct3 = v.f3; in_addr_lo = v.lo; in_alu_res = v.alu;
    in_load_word = v.word; in_pc_plus4 = v.pc;
  endtask

  // One clock: drive at negedge, track what the stage will hold, check after.
  task automatic step(input logic st, input logic fl, input vec_t v);
    @(negedge clk);
    stall = st;
    flush = fl;
    drive(v);
    v.id = next_id;
    next_id++;
    if (held_valid && (!st || fl)) exp_cnt = exp_cnt + 64'd1;
    if (fl) held_valid = 1'b0;
    else if (!st) begin
      held = v;
      held_valid = v.valid;
    end
    if (held_valid) sb.push_back(held);
    @(posedge clk);
    #1;
    check($sformatf("id%0d_wb_valid", v.id), {63'd0, wb_valid}, {63'd0, held_valid});
    check($sformatf("id%0d_instret", v.id), instret, exp_cnt);
    check($sformatf("id%0d_instret_w", v.id), {60'd0, nw_instret}, {60'd0, exp_cnt[3:0]});
  endtask

  // Async reset landing mid-cycle, held for some cycles of random traffic.
  task automatic do_reset(input int cycles);
    #2 rst_n = 1'b0;
    sb.delete();
    held_valid = 1'b0;
    exp_cnt = '0;
    #1;
    check("rst_now_wb_en", {63'd0, wb_en}, 64'd0);
    check("rst_now_wb_valid", {63'd0, wb_valid}, 64'd0);
    check("rst_now_instret", instret, 64'd0);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      stall = 1'($urandom_range(0, 1));
      flush = 1'b0;
      in_valid = 1'b1; in_rf_wr = 1'b1; in_rd = 5'($urandom_range(1, 31));
      in_wb_sel = 2'($urandom_range(0, 2)); in_funct3 = 3'($urandom);
      in_addr_lo = 2'($urandom); in_alu_res = $urandom;
      in_load_word = $urandom; in_pc_plus4 = $urandom;
      @(posedge clk);
      #1;
      check("rst_wb_en", {63'd0, wb_en}, 64'd0);
      check("rst_wb_valid", {63'd0, wb_valid}, 64'd0);
      check("rst_wb_rd", {59'd0, wb_rd}, 64'd0);
      check("rst_wb_data", {32'd0, wb_data}, 64'd0);
      check("rst_instret", instret, 64'd0);
    end
    @(negedge clk);
    stall = 1'b0;
    flush = 1'b0;
    drive(mk(0, 0, 0, 2'b00, 3'b000, 2'b00, 0, 0, 0, 0, 0));
    rst_n = 1'b1;
  endtask

  // Monitor: every valid entry on the write port must match the queue head.
  always @(negedge clk) begin
    if (wb_valid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_entry: got rd=%0d data=%h with empty scoreboard", wb_rd, wb_data);
      end else begin
        mon_e = sb.pop_front();
        check($sformatf("id%0d_wb_rd", mon_e.id), {59'd0, wb_rd}, {59'd0, mon_e.rd});
        check($sformatf("id%0d_wb_data", mon_e.id), {32'd0, wb_data}, {32'd0, mon_e.exp_data});
        check($sformatf("id%0d_wb_en", mon_e.id), {63'd0, wb_en}, {63'd0, mon_e.exp_en});
        check($sformatf("id%0d_w_data", mon_e.id), {32'd0, nw_wb_data}, {32'd0, mon_e.exp_data});
        check($sformatf("id%0d_w_en", mon_e.id), {63'd0, nw_wb_en}, {63'd0, mon_e.exp_en});
      end
    end else begin
      check("idle_wb_en", {63'd0, wb_en}, 64'd0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  localparam logic [31:0] W = 32'h8899AABB;
  vec_t bub;

  initial begin
    rst_n = 1'b0;
    stall = 1'b0;
    flush = 1'b0;
    bub = mk(0, 0, 0, 2'b00, 3'b000, 2'b00, 0, 0, 0, 0, 0);
    drive(bub);

    // T1: reset with random traffic, then release
    do_reset(3);

    // T2: load extraction
    step(0, 0, mk(1, 3, 1, 2'b01, 3'b000, 2'd2, 32'hDEAD, W, 0, 32'hFFFFFF99, 1));
    step(0, 0, mk(1, 3, 1, 2'b01, 3'b100, 2'd0, 32'hDEAD, W, 0, 32'h000000BB, 1));
    step(0, 0, mk(1, 3, 1, 2'b01, 3'b001, 2'd2, 32'hDEAD, W, 0, 32'hFFFF8899, 1));
    step(0, 0, mk(1, 3, 1, 2'b01, 3'b101, 2'd0, 32'hDEAD, W, 0, 32'h0000AABB, 1));
    step(0, 0, mk(1, 3, 1, 2'b01, 3'b010, 2'd0, 32'hDEAD, W, 0, 32'h8899AABB, 1));
    step(0, 0, mk(1, 3, 1, 2'b01, 3'b000, 2'd1, 32'hDEAD, W, 0, 32'hFFFFFFAA, 1));
    step(0, 0, mk(1, 3, 1, 2'b01, 3'b100, 2'd3, 32'hDEAD, W, 0, 32'h00000088, 1));
    step(0, 0, mk(1, 3, 1, 2'b01, 3'b001, 2'd3, 32'hDEAD, W, 0, 32'hFFFF8899, 1));
    step(0, 0, mk(1, 3, 1, 2'b01, 3'b101, 2'd1, 32'hDEAD, W, 0, 32'h0000AABB, 1));
    step(0, 0, mk(1, 3, 1, 2'b01, 3'b011, 2'd2, 32'hDEAD, W, 0, 32'h8899AABB, 1));
    step(0, 0, mk(1, 3, 1, 2'b01, 3'b000, 2'd0, 32'hDEAD, 32'h0000007F, 0, 32'h0000007F, 1));

    // T3: select and x0
    step(0, 0, mk(1, 1, 1, 2'b10, 3'b000, 2'd0, 32'h1, 0, 32'h104, 32'h104, 1));
    step(0, 0, mk(1, 0, 1, 2'b10, 3'b000, 2'd0, 32'h1, 0, 32'h104, 32'h104, 0));
    step(0, 0, mk(1, 7, 1, 2'b11, 3'b000, 2'd0, 32'h1234, W, 32'h104, 32'h0, 0));
    step(0, 0, mk(1, 9, 0, 2'b00, 3'b000, 2'd0, 32'h77, 0, 0, 32'h77, 0));

    // Reset mid-operation discards the held entry without counting
    step(0, 0, mk(1, 12, 1, 2'b00, 3'b000, 2'd0, 32'hCAFE, 0, 0, 32'hCAFE, 1));
    do_reset(1);

    // T4: stall holds outputs and the counter
    step(0, 0, mk(1, 5, 1, 2'b00, 3'b000, 2'd0, 32'h55, 0, 0, 32'h55, 1));
    for (int i = 0; i < 3; i++)
      step(1, 0, mk(1, 9, 1, 2'b00, 3'b000, 2'd0, 32'hAA + i, 0, 0, 32'hAA + i, 1));
    check("t4_instret_held", instret, 64'd0);
    step(0, 0, mk(1, 6, 1, 2'b00, 3'b000, 2'd0, 32'h66, 0, 0, 32'h66, 1));
    check("t4_instret_release", instret, 64'd1);

    // T5: flush together with stall and a valid incoming entry
    step(0, 0, mk(1, 2, 1, 2'b00, 3'b000, 2'd0, 32'h11, 0, 0, 32'h11, 1));
    step(1, 1, mk(1, 4, 1, 2'b00, 3'b000, 2'd0, 32'h22, 0, 0, 32'h22, 1));
    check("t5_flush_wb_en", {63'd0, wb_en}, 64'd0);
    check("t5_flush_wb_data", {32'd0, wb_data}, 64'd0);
    check("t5_instret", instret, 64'd3);
    step(0, 0, bub);
    check("t5_instret_once", instret, 64'd3);

    // T6: 10 valid entries interleaved with 4 bubbles, then wrap the 4-bit counter
    do_reset(1);
    for (int i = 0; i < 14; i++) begin
      if (i == 2 || i == 5 || i == 8 || i == 11) step(0, 0, bub);
      else step(0, 0, mk(1, 5'((i % 31) + 1), 1, 2'b00, 3'b000, 2'd0,
                         32'(100 + i), 0, 0, 32'(100 + i), 1));
    end
    step(0, 0, bub);
    check("t6_instret_10", instret, 64'd10);
    for (int i = 0; i < 8; i++)
      step(0, 0, mk(1, 5'(20 + i), 1, 2'b10, 3'b000, 2'd0, 0, 0,
                    32'(32'h200 + 4 * i), 32'(32'h200 + 4 * i), 1));
    step(0, 0, bub);
    check("t6_instret_18", instret, 64'd18);
    check("t6_instret_w_wrap", {60'd0, nw_instret}, 64'd2);

    @(negedge clk);
    check("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
